// File: rtl/ram4by4_pkg.sv
// Shared constants and state encoding for the 4x4 RAM host-side controller.
package ram4by4_pkg;

    // Geometry of the attached RAM; not adjustable.
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic RW_WRITE    = 1'b1;
    localparam logic RW_READ     = 1'b0;
    localparam logic CS_ACTIVE   = 1'b0;
    localparam logic CS_INACTIVE = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

endpackage

// File: rtl/ram4by4_access_timer.sv
// Loadable down-counter that times how long ram_cs is held active.
// Load sets ACCESS_CYCLES-1; o_done is high in the last running cycle.
module ram4by4_access_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_done
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Count down while running; saturate at zero so a stray run cannot wrap.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_done = i_run && (r_cnt == '0);

endmodule

// File: rtl/ram4by4_ctrl.sv
// Host-side sequencer for the 4x4 RAM: turns a valid/ready request stream into
// timed chip-select access cycles and returns read data on a response channel.
module ram4by4_ctrl
    import ram4by4_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_init_done,
    output logic              o_ram_cs,
    output logic              o_ram_rw,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    state_e            r_state,     w_state_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_ram_cs,    w_ram_cs_nxt;
    logic              r_ram_rw,    w_ram_rw_nxt;
    logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;

    logic w_timer_load;
    logic w_timer_run;
    logic w_timer_done;

    // The reset cycle in INIT stands in for the SETUP of address 0 (ram_cs is
    // still inactive then), which keeps the init sequence at 4*(1+ACCESS_CYCLES).
    assign w_timer_load = (r_state == ST_INIT) || (r_state == ST_SETUP);
    assign w_timer_run  = (r_state == ST_ACCESS);

    ram4by4_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_access_timer (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_load (w_timer_load),
        .i_run  (w_timer_run),
        .o_done (w_timer_done)
    );

    // Next-state and next-output decode; every output is a register.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_init_done_nxt = r_init_done;
        w_ram_cs_nxt    = r_ram_cs;
        w_ram_rw_nxt    = r_ram_rw;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;

        unique case (r_state)
            ST_INIT: begin
                w_ram_rw_nxt    = RW_WRITE;
                w_ram_addr_nxt  = '0;
                w_ram_wdata_nxt = '0;
                w_ram_cs_nxt    = CS_ACTIVE;
                w_state_nxt     = ST_ACCESS;
            end
            ST_IDLE: begin
                // Also covers INIT_ON_RESET=0: first clock after reset opens up.
                w_init_done_nxt = 1'b1;
                if (i_req_valid && r_req_ready) begin
                    w_req_ready_nxt = 1'b0;
                    w_ram_rw_nxt    = i_req_we ? RW_WRITE : RW_READ;
                    w_ram_addr_nxt  = i_req_addr;
                    w_ram_wdata_nxt = i_req_wdata;
                    w_state_nxt     = ST_SETUP;
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end
            ST_SETUP: begin
                w_ram_cs_nxt = CS_ACTIVE;
                w_state_nxt  = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_timer_done) begin
                    w_ram_cs_nxt = CS_INACTIVE;
                    if (!r_init_done) begin
                        // Still zero-filling: step to the next word or finish.
                        if (r_ram_addr == ADDR_LAST) begin
                            w_init_done_nxt = 1'b1;
                            w_req_ready_nxt = 1'b1;
                            w_state_nxt     = ST_IDLE;
                        end else begin
                            w_ram_addr_nxt = r_ram_addr + 1'b1;
                            w_state_nxt    = ST_SETUP;
                        end
                    end else if (r_ram_rw == RW_WRITE) begin
                        w_req_ready_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_rsp_rdata_nxt = i_ram_rdata;
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_ram_cs_nxt    = CS_INACTIVE;
                w_req_ready_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ram_cs immediately.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= RESET_STATE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_init_done <= 1'b0;
            r_ram_cs    <= CS_INACTIVE;
            r_ram_rw    <= RW_READ;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_init_done <= w_init_done_nxt;
            r_ram_cs    <= w_ram_cs_nxt;
            r_ram_rw    <= w_ram_rw_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_init_done = r_init_done;
    assign o_ram_cs    = r_ram_cs;
    assign o_ram_rw    = r_ram_rw;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;

endmodule
